// File: rtl/spi_slave_pkg.sv
// ============================================================================
// Module      : spi_slave_pkg
// Description : Shared constants and helpers for the SPI mode-3 slave.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package spi_slave_pkg;

    localparam int C_DEFAULT_WIDTH   = 8;
    localparam int C_SYNC_DEPTH_CTRL = 3;   // SCK and SSEL
    localparam int C_SYNC_DEPTH_DATA = 2;   // MOSI

    function automatic int cnt_width(input int width);
        return (width > 1) ? $clog2(width) : 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/spi_sync.sv
// ============================================================================
// Module      : spi_sync
// Description : Parameterised-depth synchroniser with rise/fall detection
//               taken from the last two stages.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module spi_sync
    import spi_slave_pkg::*;
#(
    parameter int   DEPTH   = C_SYNC_DEPTH_CTRL,
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic i_async,
    output logic o_sync,
    output logic o_rise,
    output logic o_fall
);

    logic [DEPTH-1:0] r_stage_q;
    logic [DEPTH-1:0] w_stage_d;

    always_comb begin
        w_stage_d = {r_stage_q[DEPTH-2:0], i_async};
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_stage_q <= {DEPTH{RST_VAL}};
        end else begin
            r_stage_q <= w_stage_d;
        end
    end

    assign o_sync = r_stage_q[DEPTH-1];
    assign o_rise = (r_stage_q[DEPTH-1 -: 2] == 2'b01);
    assign o_fall = (r_stage_q[DEPTH-1 -: 2] == 2'b10);

endmodule

`default_nettype wire

// File: rtl/spi_slave.sv
// ============================================================================
// Module      : spi_slave
// Description : SPI mode-3 (CPOL=1, CPHA=1) slave, MSB first, oversampled
//               by clk. Optional macro SPI_MISO_TRISTATE_EN floats MISO
//               while the slave is deselected or in reset.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module spi_slave
    import spi_slave_pkg::*;
#(
    parameter int WIDTH = C_DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             SCK,
    input  logic             MOSI,
    output logic             MISO,
    input  logic             SSEL,
    output logic             LED,
    output logic [WIDTH-1:0] byte_data_received,
    output logic             byte_received,
    input  logic [WIDTH-1:0] byte_sent
);

    localparam int              CNT_W      = cnt_width(WIDTH);
    localparam logic [CNT_W-1:0] C_LAST_BIT = CNT_W'(WIDTH - 1);

    logic w_sck_sync_unused;
    logic w_sck_rise;
    logic w_sck_fall;
    logic w_ssel_sync;
    logic w_ssel_rise_unused;
    logic w_ssel_fall;
    logic w_mosi;
    logic w_mosi_rise_unused;
    logic w_mosi_fall_unused;

    spi_sync #(.DEPTH(C_SYNC_DEPTH_CTRL), .RST_VAL(1'b1)) u_sync_sck (
        .clk     (clk),
        .rst     (rst),
        .i_async (SCK),
        .o_sync  (w_sck_sync_unused),
        .o_rise  (w_sck_rise),
        .o_fall  (w_sck_fall)
    );

    spi_sync #(.DEPTH(C_SYNC_DEPTH_CTRL), .RST_VAL(1'b1)) u_sync_ssel (
        .clk     (clk),
        .rst     (rst),
        .i_async (SSEL),
        .o_sync  (w_ssel_sync),
        .o_rise  (w_ssel_rise_unused),
        .o_fall  (w_ssel_fall)
    );

    spi_sync #(.DEPTH(C_SYNC_DEPTH_DATA), .RST_VAL(1'b0)) u_sync_mosi (
        .clk     (clk),
        .rst     (rst),
        .i_async (MOSI),
        .o_sync  (w_mosi),
        .o_rise  (w_mosi_rise_unused),
        .o_fall  (w_mosi_fall_unused)
    );

    logic             w_ssel_active;
    logic             w_sample;
    logic [WIDTH-1:0] w_rx_next;

    logic [WIDTH-1:0] r_rx_shift_q,      w_rx_shift_d;
    logic [CNT_W-1:0] r_bitcnt_q,        w_bitcnt_d;
    logic [WIDTH-1:0] r_tx_shift_q,      w_tx_shift_d;
    logic             r_miso_q,          w_miso_d;
    logic             r_led_q,           w_led_d;
    logic [WIDTH-1:0] r_byte_data_q,     w_byte_data_d;
    logic             r_byte_received_q, w_byte_received_d;

    assign w_ssel_active = ~w_ssel_sync;
    assign w_sample      = w_ssel_active & w_sck_rise;
    assign w_rx_next     = {r_rx_shift_q[WIDTH-2:0], w_mosi};

    always_comb begin
        w_rx_shift_d      = r_rx_shift_q;
        w_bitcnt_d        = r_bitcnt_q;
        w_tx_shift_d      = r_tx_shift_q;
        w_miso_d          = r_miso_q;
        w_led_d           = r_led_q;
        w_byte_data_d     = r_byte_data_q;
        w_byte_received_d = 1'b0;

        // Deselect holds the counter at zero, which is also what discards an aborted frame.
        if (!w_ssel_active) begin
            w_bitcnt_d = '0;
        end else if (w_sample) begin
            w_rx_shift_d = w_rx_next;
            if (r_bitcnt_q == C_LAST_BIT) begin
                w_bitcnt_d        = '0;
                w_byte_data_d     = w_rx_next;
                w_led_d           = w_mosi;
                w_byte_received_d = 1'b1;
            end else begin
                w_bitcnt_d = r_bitcnt_q + 1'b1;
            end
        end

        // Reloading on the completion pulse lets frames run back to back under one select.
        if (w_ssel_fall || r_byte_received_q) begin
            w_tx_shift_d = byte_sent;
        end else if (w_ssel_active && w_sck_fall) begin
            w_miso_d     = r_tx_shift_q[WIDTH-1];
            w_tx_shift_d = {r_tx_shift_q[WIDTH-2:0], 1'b0};
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rx_shift_q      <= '0;
            r_bitcnt_q        <= '0;
            r_tx_shift_q      <= '0;
            r_miso_q          <= 1'b0;
            r_led_q           <= 1'b0;
            r_byte_data_q     <= '0;
            r_byte_received_q <= 1'b0;
        end else begin
            r_rx_shift_q      <= w_rx_shift_d;
            r_bitcnt_q        <= w_bitcnt_d;
            r_tx_shift_q      <= w_tx_shift_d;
            r_miso_q          <= w_miso_d;
            r_led_q           <= w_led_d;
            r_byte_data_q     <= w_byte_data_d;
            r_byte_received_q <= w_byte_received_d;
        end
    end

    assign LED                = r_led_q;
    assign byte_data_received = r_byte_data_q;
    assign byte_received      = r_byte_received_q;

`ifdef SPI_MISO_TRISTATE_EN
    assign MISO = (rst && w_ssel_active) ? r_miso_q : 1'bz;
`else
    assign MISO = r_miso_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_spi_slave.sv
// ============================================================================
// Module      : tb_spi_slave
// Description : Self-checking bench for spi_slave; drives mode-3 frames from
//               a behavioural master and compares against frame-level rules.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_spi_slave;

    localparam int W    = 8;
    localparam int HALF = 8;

    logic         clk       = 1'b0;
    logic         rst       = 1'b0;
    logic         SCK       = 1'b1;
    logic         MOSI      = 1'b0;
    logic         SSEL      = 1'b1;
    logic [W-1:0] byte_sent = '0;
    wire          MISO;
    wire          LED;
    wire  [W-1:0] byte_data_received;
    wire          byte_received;

    int n_tests = 0;
    int n_fail  = 0;

    logic [W-1:0] rxq[$];
    logic         ledq[$];
    time          pulse_t = 0;
    time          rise_t  = 0;

    // model state: last completed frame and last bit shifted out
    logic [W-1:0] exp_last     = '0;
    logic         exp_idle_bit = 1'b0;

    spi_slave #(.WIDTH(W)) dut (
        .clk                (clk),
        .rst                (rst),
        .SCK                (SCK),
        .MOSI               (MOSI),
        .MISO               (MISO),
        .SSEL               (SSEL),
        .LED                (LED),
        .byte_data_received (byte_data_received),
        .byte_received      (byte_received),
        .byte_sent          (byte_sent)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (byte_received === 1'b1) begin
            rxq.push_back(byte_data_received);
            ledq.push_back(LED);
            pulse_t = $time;
        end
    end

    function automatic logic miso_inactive(input logic held);
`ifdef SPI_MISO_TRISTATE_EN
        return 1'bz;
`else
        return held;
`endif
    endfunction

    task automatic wait_clks(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic spi_xfer(input logic [31:0] data, input int nbits, output logic [31:0] miso_bits);
        miso_bits = '0;
        for (int i = nbits - 1; i >= 0; i--) begin
            SCK  = 1'b0;
            MOSI = data[i];
            wait_clks(HALF);
            miso_bits = {miso_bits[30:0], MISO};
            SCK    = 1'b1;
            rise_t = $time;
            wait_clks(HALF);
        end
    endtask

    task automatic do_frame(input logic [W-1:0] tx, input logic [31:0] data, input int nbits,
                            output logic [31:0] miso_bits);
        byte_sent = tx;
        SSEL = 1'b0;
        wait_clks(6);
        spi_xfer(data, nbits, miso_bits);
        wait_clks(6);
        SSEL = 1'b1;
        wait_clks(6);
        if (nbits >= W && (nbits % W) == 0) begin
            exp_last     = data[W-1:0];
            exp_idle_bit = tx[0];
        end
    endtask

    task automatic test_reset;
        rst = 1'b0;
        wait_clks(3);
        n_tests++;
        if (byte_received !== 1'b0) begin
            n_fail++; $display("FAIL reset_pulse: got %b want 0", byte_received);
        end
        n_tests++;
        if (byte_data_received !== 8'h00) begin
            n_fail++; $display("FAIL reset_data: got %h want 00", byte_data_received);
        end
        n_tests++;
        if (LED !== 1'b0) begin
            n_fail++; $display("FAIL reset_led: got %b want 0", LED);
        end
        n_tests++;
        if (MISO !== miso_inactive(1'b0)) begin
            n_fail++; $display("FAIL reset_miso: got %b want %b", MISO, miso_inactive(1'b0));
        end
        rst = 1'b1;
        wait_clks(4);
        n_tests++;
        if (MISO !== miso_inactive(1'b0)) begin
            n_fail++; $display("FAIL post_reset_miso: got %b want %b", MISO, miso_inactive(1'b0));
        end
    endtask

    task automatic test_single_frame;
        logic [31:0] mb;
        rxq.delete(); ledq.delete();
        do_frame(8'h00, 32'hDD, 8, mb);
        n_tests++;
        if (rxq.size() != 1) begin
            n_fail++; $display("FAIL single_pulses: got %0d want 1", rxq.size());
        end
        n_tests++;
        if (byte_data_received !== 8'hDD) begin
            n_fail++; $display("FAIL single_data: got %h want dd", byte_data_received);
        end
        n_tests++;
        if (LED !== 1'b1) begin
            n_fail++; $display("FAIL single_led: got %b want 1", LED);
        end
        n_tests++;
        if (!(pulse_t > rise_t && (pulse_t - rise_t) <= 45)) begin
            n_fail++; $display("FAIL single_latency: got %0t after last rise want <= 45", pulse_t - rise_t);
        end
    endtask

    task automatic test_transmit;
        logic [31:0] mb;
        logic [W-1:0] d;
        d = W'($urandom);
        rxq.delete(); ledq.delete();
        do_frame(8'hA5, {24'h0, d}, 8, mb);
        n_tests++;
        if (mb[7:0] !== 8'hA5) begin
            n_fail++; $display("FAIL transmit_miso: got %h want a5", mb[7:0]);
        end
        n_tests++;
        if (rxq.size() != 1 || byte_data_received !== d) begin
            n_fail++; $display("FAIL transmit_rx: got %h (%0d pulses) want %h", byte_data_received, rxq.size(), d);
        end
    endtask

    task automatic test_back_to_back;
        logic [31:0] mb;
        rxq.delete(); ledq.delete();
        do_frame(8'h5A, 32'h3C81, 16, mb);
        n_tests++;
        if (rxq.size() != 2) begin
            n_fail++; $display("FAIL b2b_pulses: got %0d want 2", rxq.size());
        end else begin
            n_tests++;
            if (rxq[0] !== 8'h3C || rxq[1] !== 8'h81) begin
                n_fail++; $display("FAIL b2b_data: got %h,%h want 3c,81", rxq[0], rxq[1]);
            end
        end
        n_tests++;
        if (LED !== 1'b1) begin
            n_fail++; $display("FAIL b2b_led: got %b want 1", LED);
        end
        n_tests++;
        if (mb[15:0] !== 16'h5A5A) begin
            n_fail++; $display("FAIL b2b_miso: got %h want 5a5a", mb[15:0]);
        end
    endtask

    task automatic test_abort;
        logic [31:0] mb;
        logic [W-1:0] prior;
        prior = exp_last;
        rxq.delete(); ledq.delete();
        byte_sent = W'($urandom);
        SSEL = 1'b0;
        wait_clks(6);
        spi_xfer($urandom, 5, mb);
        wait_clks(6);
        SSEL = 1'b1;
        wait_clks(6);
        n_tests++;
        if (rxq.size() != 0) begin
            n_fail++; $display("FAIL abort_pulse: got %0d want 0", rxq.size());
        end
        n_tests++;
        if (byte_data_received !== prior || LED !== prior[0]) begin
            n_fail++; $display("FAIL abort_hold: got %h/%b want %h/%b", byte_data_received, LED, prior, prior[0]);
        end
        do_frame(W'($urandom), 32'h42, 8, mb);
        n_tests++;
        if (rxq.size() != 1 || byte_data_received !== 8'h42 || LED !== 1'b0) begin
            n_fail++; $display("FAIL abort_next: got %h/%b (%0d pulses) want 42/0", byte_data_received, LED, rxq.size());
        end
    endtask

    task automatic test_reset_midframe;
        logic [31:0] mb;
        rxq.delete(); ledq.delete();
        byte_sent = 8'hFF;
        SSEL = 1'b0;
        wait_clks(6);
        spi_xfer(32'h7, 3, mb);
        rst = 1'b0;
        wait_clks(3);
        n_tests++;
        if (byte_data_received !== 8'h00 || LED !== 1'b0 || byte_received !== 1'b0
            || MISO !== miso_inactive(1'b0)) begin
            n_fail++; $display("FAIL midreset_outputs: got %h/%b/%b/%b want 00/0/0/%b",
                               byte_data_received, LED, byte_received, MISO, miso_inactive(1'b0));
        end
        SSEL = 1'b1;
        SCK  = 1'b1;
        wait_clks(3);
        rst = 1'b1;
        wait_clks(6);
        do_frame(W'($urandom), 32'hF0, 8, mb);
        n_tests++;
        if (rxq.size() != 1 || byte_data_received !== 8'hF0 || LED !== 1'b0) begin
            n_fail++; $display("FAIL midreset_next: got %h/%b (%0d pulses) want f0/0", byte_data_received, LED, rxq.size());
        end
    endtask

    task automatic test_idle_clocks;
        rxq.delete(); ledq.delete();
        SSEL = 1'b1;
        for (int i = 0; i < 8; i++) begin
            SCK  = 1'b0;
            MOSI = 1'($urandom);
            wait_clks(HALF);
            SCK  = 1'b1;
            wait_clks(HALF);
        end
        n_tests++;
        if (rxq.size() != 0 || byte_data_received !== exp_last) begin
            n_fail++; $display("FAIL idle_rx: got %h (%0d pulses) want %h", byte_data_received, rxq.size(), exp_last);
        end
        n_tests++;
        if (MISO !== miso_inactive(exp_idle_bit)) begin
            n_fail++; $display("FAIL idle_miso: got %b want %b", MISO, miso_inactive(exp_idle_bit));
        end
    endtask

    task automatic test_random;
        logic [31:0] mb;
        logic [W-1:0] tx;
        logic [31:0] d;
        int nfr;
        for (int k = 0; k < 8; k++) begin
            nfr = (k < 5) ? 1 : 3;
            tx  = W'($urandom);
            d   = $urandom & ((nfr == 1) ? 32'hFF : 32'hFF_FFFF);
            rxq.delete(); ledq.delete();
            do_frame(tx, d, nfr * W, mb);
            n_tests++;
            if (rxq.size() != nfr) begin
                n_fail++; $display("FAIL rand_pulses[%0d]: got %0d want %0d", k, rxq.size(), nfr);
            end else begin
                for (int f = 0; f < nfr; f++) begin
                    n_tests++;
                    if (rxq[f] !== d[(nfr-1-f)*W +: W] || ledq[f] !== d[(nfr-1-f)*W]) begin
                        n_fail++; $display("FAIL rand_data[%0d.%0d]: got %h/%b want %h", k, f, rxq[f], ledq[f], d[(nfr-1-f)*W +: W]);
                    end
                    n_tests++;
                    if (mb[(nfr-1-f)*W +: W] !== tx) begin
                        n_fail++; $display("FAIL rand_miso[%0d.%0d]: got %h want %h", k, f, mb[(nfr-1-f)*W +: W], tx);
                    end
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_transmit();
        test_back_to_back();
        test_abort();
        test_reset_midframe();
        test_idle_clocks();
        test_random();
        test_idle_clocks();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/spi_slave.md
SPI_SLAVE -- requirements
Module: spi_slave

Interface
REQ-001 Parameter WIDTH, default 8: frame length in bits; also the width of the receive and transmit data ports.
REQ-002 Ports, in order:
- clk, input, 1: the single system clock; all logic is on its rising edge.
- rst, input, 1: asynchronous, active-low reset.
REQ-003 SCK, input, 1: SPI serial clock from the master; asynchronous to clk; idles high (CPOL=1).
REQ-004 MOSI, input, 1: serial data from the master, MSB first.
REQ-005 MISO, output, 1: serial data to the master, MSB first.
REQ-006 SSEL, input, 1: slave select, active low.
REQ-007 LED, output, 1: bit 0 of the last completed received frame.
REQ-008 byte_data_received, output, WIDTH: last completed received frame.
REQ-009 byte_received, output, 1: single-clk pulse marking a completed frame.
REQ-010 byte_sent, input, WIDTH: frame to transmit; sampled at each frame load.

Function
REQ-011 SCK and SSEL SHALL pass through 3-flop synchronisers and MOSI through a 2-flop synchroniser.
- SCK rise and fall SHALL be detected from the last two SCK stages.
- SSEL active = synchronised SSEL low.
- Frame start = synchronised SSEL high-to-low transition.
REQ-012 Timing is SPI mode 3: MOSI is sampled on each detected SCK rise while SSEL is active; the next MISO bit is driven on each detected SCK fall while SSEL is active.
REQ-013 The receive shift register SHALL shift left and insert MOSI at bit 0 on each sample, so the first bit received lands at the MSB.
REQ-014 Bit counter:
- ranges 0..WIDTH-1;
- increments on each sample;
- wraps to 0 after the WIDTH-th sample;
- is held at 0 while SSEL is inactive.
REQ-015 On the WIDTH-th sample the following SHALL all occur in the same clk cycle:
- byte_data_received <= completed shift value;
- LED <= bit 0 of that value;
- byte_received = 1 for exactly one clk cycle.
REQ-016 Latency: byte_received SHALL assert no more than 4 clk cycles after the final SCK rising edge at the pin.
REQ-017 Transmit load: the transmit register SHALL load byte_sent at frame start and in the cycle byte_received pulses, which supports back-to-back frames under one SSEL.
REQ-018 On each SCK fall: MISO <= transmit register MSB, and the transmit register shifts left with 0 filled in. The first fall of a frame therefore presents the MSB of byte_sent.
REQ-019 Abort: if SSEL deasserts mid-frame, the partial frame SHALL be discarded, with no byte_received pulse and byte_data_received and LED unchanged.
REQ-020 byte_data_received and LED SHALL hold their values until the next completed frame.
REQ-021 Timing requirement: SCK high and low phases are each at least 3 clk periods; SSEL high time between frames is at least 3 clk periods.
REQ-022 If SCK edges arrive while SSEL is inactive, the block SHALL ignore them for both receive and transmit.

Reset
REQ-023 While rst is low, the block SHALL clear:
- all synchroniser flops (SCK flops preset to 1, SSEL flops preset to 1);
- both shift registers and the bit counter;
- MISO, LED, byte_received and byte_data_received, all to 0.
REQ-024 Reset asserted mid-frame SHALL abort the frame; after release, reception restarts only at the next SSEL falling edge.

Configuration
REQ-025 Macro SPI_MISO_TRISTATE_EN:
- When defined, MISO SHALL be high-impedance whenever synchronised SSEL is inactive and during reset.
- When undefined, MISO SHALL always be driven, and SHALL hold its last value while SSEL is inactive.

Structure
REQ-026 Package spi_slave_pkg SHALL hold:
- the default WIDTH;
- the synchroniser depth constants (3 for SCK/SSEL, 2 for MOSI);
- the bit-counter width function, $clog2(WIDTH).
REQ-027 Sub-module spi_sync SHALL be the only sub-module; it is a parameterised-depth synchroniser with rise/fall detect outputs, instantiated for SCK, SSEL and MOSI.

Verification
REQ-028 Single frame: SSEL low, 8 mode-3 bits 1,1,0,1,1,1,0,1 with SCK half-period 8 clk, then SSEL high.
- Expected: one byte_received pulse; byte_data_received = 0xDD; LED = 1.
REQ-029 Transmit: byte_sent = 0xA5 at SSEL fall.
- Expected: MISO sampled on the 8 SCK rises reads 1,0,1,0,0,1,0,1.
REQ-030 Back-to-back: 16 bits 0x3C then 0x81 under one SSEL, byte_sent = 0x5A.
- Expected: two pulses carrying 0x3C then 0x81, LED = 1 after the second; MISO returns 0x5A in both frames.
REQ-031 Abort: SSEL rises after 5 bits.
- Expected: no pulse; prior byte_data_received unchanged; the next full frame 0x42 is received correctly.
REQ-032 Reset: rst asserted after 3 bits.
- Expected: all outputs 0; the subsequent frame 0xF0 is received correctly, and LED = 0.
REQ-033 Idle clocks: 8 SCK toggles with SSEL high.
- Expected: no pulse; with SPI_MISO_TRISTATE_EN defined, MISO = Z.
